id_stage_hz: RTL and testbench

ID_STAGE_HZ -- requirements
Module: id_stage_hz

---
 rtl/id_stage_hz_pkg.sv | 66 ++++++
 rtl/id_stage_hz_if.sv | 50 +++++
 rtl/id_regfile.sv | 44 ++++
 rtl/id_stage_hz.sv | 106 ++++++++++
 tb/tb_id_stage_hz.sv | 323 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/id_stage_hz_pkg.sv
// Shared decode definitions for the ID stage: opcodes, control-bundle layout
// and the opcode -> control lookup used by the stage.
package id_stage_hz_pkg;

    // Control bundle widths
    localparam int WB_W  = 2;
    localparam int MEM_W = 3;
    localparam int EX_W  = 4;

    // Bit positions inside o_wb_ctrl {MemtoReg, RegWrite}
    localparam int WB_MEMTOREG = 1;
    localparam int WB_REGWRITE = 0;

    // Bit positions inside o_mem_ctrl {MemWrite, MemRead, Branch}
    localparam int MEM_WRITE  = 2;
    localparam int MEM_READ   = 1;
    localparam int MEM_BRANCH = 0;

    // Bit positions inside o_ex_ctrl {ALUSrc, ALUOp[1:0], RegDst}
    localparam int EX_ALUSRC   = 3;
    localparam int EX_ALUOP_HI = 2;
    localparam int EX_ALUOP_LO = 1;
    localparam int EX_REGDST   = 0;

    typedef enum logic [5:0] {
        OP_RTYPE = 6'h00,
        OP_J     = 6'h02,
        OP_BEQ   = 6'h04,
        OP_ADDI  = 6'h08,
        OP_LW    = 6'h23,
        OP_SW    = 6'h2B
    } opcode_e;

    typedef struct packed {
        logic             legal;
        logic             jump;
        logic [WB_W-1:0]  wb;
        logic [MEM_W-1:0] mem;
        logic [EX_W-1:0]  ex;
    } decode_t;

    // Register-address width: enough bits for reg_cnt entries, never below 5
    // so the 5-bit instruction fields always fit.
    function automatic int ra_width(input int reg_cnt);
        int w;
        w = $clog2(reg_cnt);
        return (w < 5) ? 5 : w;
    endfunction

    // Opcode to control bundle; j is legal but carries no pipeline controls.
    function automatic decode_t decode_op(input logic [5:0] op);
        decode_t d;
        d = '0;
        case (op)
            OP_RTYPE: begin d.legal = 1'b1; d.wb = 2'b01; d.mem = 3'b000; d.ex = 4'b0101; end
            OP_LW:    begin d.legal = 1'b1; d.wb = 2'b11; d.mem = 3'b010; d.ex = 4'b1000; end
            OP_SW:    begin d.legal = 1'b1; d.wb = 2'b00; d.mem = 3'b100; d.ex = 4'b1000; end
            OP_BEQ:   begin d.legal = 1'b1; d.wb = 2'b00; d.mem = 3'b001; d.ex = 4'b0010; end
            OP_ADDI:  begin d.legal = 1'b1; d.wb = 2'b01; d.mem = 3'b000; d.ex = 4'b1000; end
            OP_J:     begin d.legal = 1'b1; d.jump = 1'b1; end
            default:  d = '0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/id_stage_hz_if.sv
// Bundle of IF/ID inputs, writeback port, pipeline control and ID/EX outputs
// of the decode stage. master = the stage itself, slave = its surroundings.
interface id_stage_hz_if
    import id_stage_hz_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int RA_W   = 5
);
    logic              i_if_valid;
    logic [31:0]       i_instr;
    logic [DATA_W-1:0] i_next_pc;
    logic              i_wb_we;
    logic [RA_W-1:0]   i_wb_reg;
    logic [DATA_W-1:0] i_wb_data;
    logic              i_flush;
    logic              i_hold;

    logic              o_stall;
    logic              o_jump;
    logic [DATA_W-1:0] o_jump_tgt;
    logic              o_illegal;

    logic              o_valid;
    logic [DATA_W-1:0] o_next_pc;
    logic [DATA_W-1:0] o_rs_data;
    logic [DATA_W-1:0] o_rt_data;
    logic [DATA_W-1:0] o_imm;
    logic [RA_W-1:0]   o_rs;
    logic [RA_W-1:0]   o_rt;
    logic [RA_W-1:0]   o_rd;
    logic [WB_W-1:0]   o_wb_ctrl;
    logic [MEM_W-1:0]  o_mem_ctrl;
    logic [EX_W-1:0]   o_ex_ctrl;

    modport master (
        input  i_if_valid, i_instr, i_next_pc, i_wb_we, i_wb_reg, i_wb_data,
               i_flush, i_hold,
        output o_stall, o_jump, o_jump_tgt, o_illegal,
               o_valid, o_next_pc, o_rs_data, o_rt_data, o_imm,
               o_rs, o_rt, o_rd, o_wb_ctrl, o_mem_ctrl, o_ex_ctrl
    );

    modport slave (
        output i_if_valid, i_instr, i_next_pc, i_wb_we, i_wb_reg, i_wb_data,
               i_flush, i_hold,
        input  o_stall, o_jump, o_jump_tgt, o_illegal,
               o_valid, o_next_pc, o_rs_data, o_rt_data, o_imm,
               o_rs, o_rt, o_rd, o_wb_ctrl, o_mem_ctrl, o_ex_ctrl
    );
endinterface

// File: rtl/id_regfile.sv
// Register file: REG_CNT x DATA_W, two asynchronous read ports with
// write-through bypass, one write port. Register 0 is hard-wired to zero.
module id_regfile #(
    parameter int DATA_W  = 32,
    parameter int REG_CNT = 32,
    parameter int RA_W    = 5
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_we,
    input  logic [RA_W-1:0]   i_wa,
    input  logic [DATA_W-1:0] i_wd,
    input  logic [RA_W-1:0]   i_ra_a,
    input  logic [RA_W-1:0]   i_ra_b,
    output logic [DATA_W-1:0] o_rd_a,
    output logic [DATA_W-1:0] o_rd_b
);

    logic [DATA_W-1:0] regs [REG_CNT];

    // Storage update: clear everything on reset, otherwise accept writebacks to nonzero registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            // NOTE: the whole array is reset because the stage must come out of
            // reset with every register reading zero; this forces flops, not RAM.
            for (int i = 0; i < REG_CNT; i++) begin
                regs[i] <= '0;
            end
        end else if (i_we && (i_wa != '0)) begin
            regs[i_wa] <= i_wd;
        end
    end

    // Read ports: $0 reads zero, a same-cycle write to the addressed register is forwarded.
    always_comb begin
        o_rd_a = regs[i_ra_a];
        o_rd_b = regs[i_ra_b];
        if (i_we && (i_wa == i_ra_a)) o_rd_a = i_wd;
        if (i_we && (i_wa == i_ra_b)) o_rd_b = i_wd;
        if (i_ra_a == '0) o_rd_a = '0;
        if (i_ra_b == '0) o_rd_b = '0;
    end

endmodule

// File: rtl/id_stage_hz.sv
// Instruction decode stage with load-use hazard detection, jump redirect,
// illegal-opcode reporting and the ID/EX pipeline register.
module id_stage_hz
    import id_stage_hz_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int REG_CNT = 32
) (
    input logic          i_clk,
    input logic          i_rst,
    id_stage_hz_if.master bus
);

    localparam int RA_W = ra_width(REG_CNT);

    logic [5:0]        opcode;
    logic [RA_W-1:0]   rs;
    logic [RA_W-1:0]   rt;
    logic [RA_W-1:0]   rd;
    decode_t           dec;
    logic [DATA_W-1:0] imm;
    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] rt_data;
    logic              uses_rt;
    logic              hazard;
    logic              fire;
    logic              load_valid;

    id_regfile #(
        .DATA_W  (DATA_W),
        .REG_CNT (REG_CNT),
        .RA_W    (RA_W)
    ) u_regfile (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_we   (bus.i_wb_we),
        .i_wa   (bus.i_wb_reg),
        .i_wd   (bus.i_wb_data),
        .i_ra_a (rs),
        .i_ra_b (rt),
        .o_rd_a (rs_data),
        .o_rd_b (rt_data)
    );

    // Field extraction, decode and load-use hazard detection against the instruction now in EX.
    always_comb begin
        // NOTE: every signal of this block is assigned on every path, so no latch is inferred.
        opcode  = bus.i_instr[31:26];
        rs      = RA_W'(bus.i_instr[25:21]);
        rt      = RA_W'(bus.i_instr[20:16]);
        rd      = RA_W'(bus.i_instr[15:11]);
        dec     = decode_op(opcode);
        imm     = {{(DATA_W-16){bus.i_instr[15]}}, bus.i_instr[15:0]};
        // Only these formats actually read rt as a source operand.
        uses_rt = (opcode == OP_RTYPE) || (opcode == OP_SW) || (opcode == OP_BEQ);
        hazard  = bus.i_if_valid && bus.o_valid && bus.o_mem_ctrl[MEM_READ] &&
                  (bus.o_rt != '0) &&
                  ((bus.o_rt == rs) || ((bus.o_rt == rt) && uses_rt));
        // A squash makes the load in EX irrelevant, so it overrides the hazard stall.
        bus.o_stall    = bus.i_hold || (hazard && !bus.i_flush);
        fire           = bus.i_if_valid && !bus.o_stall && !bus.i_flush;
        bus.o_jump     = fire && dec.jump;
        bus.o_illegal  = fire && !dec.legal;
        bus.o_jump_tgt = {bus.i_next_pc[DATA_W-1:28], bus.i_instr[25:0], 2'b00};
        // j and illegal opcodes retire in ID and send a bubble down the pipe.
        load_valid     = bus.i_if_valid && dec.legal && !dec.jump;
    end

    // ID/EX register: reset, then flush, hold, hazard bubble, or load the decoded instruction.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            // NOTE: sequential state uses non-blocking assignments so every flop
            // samples pre-edge values regardless of statement order.
            bus.o_valid    <= 1'b0;
            bus.o_next_pc  <= '0;
            bus.o_rs_data  <= '0;
            bus.o_rt_data  <= '0;
            bus.o_imm      <= '0;
            bus.o_rs       <= '0;
            bus.o_rt       <= '0;
            bus.o_rd       <= '0;
            bus.o_wb_ctrl  <= '0;
            bus.o_mem_ctrl <= '0;
            bus.o_ex_ctrl  <= '0;
        end else if (bus.i_flush || (!bus.i_hold && hazard)) begin
            // Bubble: data fields are don't-care and simply left as they were.
            bus.o_valid    <= 1'b0;
            bus.o_wb_ctrl  <= '0;
            bus.o_mem_ctrl <= '0;
            bus.o_ex_ctrl  <= '0;
        end else if (!bus.i_hold) begin
            bus.o_valid    <= load_valid;
            bus.o_next_pc  <= bus.i_next_pc;
            bus.o_rs_data  <= rs_data;
            bus.o_rt_data  <= rt_data;
            bus.o_imm      <= imm;
            bus.o_rs       <= rs;
            bus.o_rt       <= rt;
            bus.o_rd       <= rd;
            bus.o_wb_ctrl  <= load_valid ? dec.wb  : '0;
            bus.o_mem_ctrl <= load_valid ? dec.mem : '0;
            bus.o_ex_ctrl  <= load_valid ? dec.ex  : '0;
        end
    end

endmodule

// File: tb/tb_id_stage_hz.sv
// Self-checking bench for id_stage_hz: reset state, decode table, hand-written
// hazard/bypass/flush/hold/jump sequences, a 64-bit configuration, and a
// randomized run against a behavioural model.
`timescale 1ns/1ps
module tb_id_stage_hz;
    import id_stage_hz_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    id_stage_hz_if #(.DATA_W(32), .RA_W(5)) b32 ();
    id_stage_hz_if #(.DATA_W(64), .RA_W(6)) b64 ();

    id_stage_hz #(.DATA_W(32), .REG_CNT(32)) u32 (.i_clk(clk), .i_rst(rst), .bus(b32.master));
    id_stage_hz #(.DATA_W(64), .REG_CNT(64)) u64 (.i_clk(clk), .i_rst(rst), .bus(b64.master));

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Advance one clock; inputs are then driven 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle32();
        b32.i_if_valid = 1'b0; b32.i_instr = '0; b32.i_next_pc = '0;
        b32.i_wb_we = 1'b0; b32.i_wb_reg = '0; b32.i_wb_data = '0;
        b32.i_flush = 1'b0; b32.i_hold = 1'b0;
    endtask

    task automatic idle64();
        b64.i_if_valid = 1'b0; b64.i_instr = '0; b64.i_next_pc = '0;
        b64.i_wb_we = 1'b0; b64.i_wb_reg = '0; b64.i_wb_data = '0;
        b64.i_flush = 1'b0; b64.i_hold = 1'b0;
    endtask

    task automatic issue32(input logic [31:0] instr);
        b32.i_instr = instr; b32.i_if_valid = 1'b1; b32.i_next_pc = 32'h0000_1004;
    endtask

    // Decode table records
    typedef struct {
        logic [31:0] instr;
        logic        if_valid;
        logic        exp_valid;
        logic [8:0]  exp_ctrl;   // {wb, mem, ex}
        logic [31:0] exp_imm;
        logic        exp_jump;
        logic        exp_illegal;
    } vec_t;
    vec_t vecs [8];

    // Behavioural reference: control values by opcode, as listed for the ISA subset
    function automatic void spec_ctrl(input logic [5:0] op, output logic legal,
                                      output logic is_j, output logic [8:0] ctrl);
        legal = 1'b1; is_j = 1'b0; ctrl = 9'b0;
        if      (op == 6'h00) ctrl = {2'b01, 3'b000, 4'b0101};
        else if (op == 6'h23) ctrl = {2'b11, 3'b010, 4'b1000};
        else if (op == 6'h2B) ctrl = {2'b00, 3'b100, 4'b1000};
        else if (op == 6'h04) ctrl = {2'b00, 3'b001, 4'b0010};
        else if (op == 6'h08) ctrl = {2'b01, 3'b000, 4'b1000};
        else if (op == 6'h02) is_j = 1'b1;
        else legal = 1'b0;
    endfunction

    // Model state
    logic [31:0] m_regs [32];
    logic        m_valid;
    logic [8:0]  m_ctrl;
    logic [31:0] m_next_pc, m_rs_data, m_rt_data, m_imm;
    logic [4:0]  m_rs, m_rt, m_rd;

    function automatic logic [31:0] model_read(input logic [4:0] a, input logic we,
                                               input logic [4:0] wa, input logic [31:0] wd);
        if (a == 5'd0) return 32'h0;
        if (we && wa == a) return wd;
        return m_regs[a];
    endfunction

    initial begin
        // ---------------- reset ----------------
        rst = 1'b1;
        idle32(); idle64();
        // Writeback and a jump presented during reset: reset wins for state,
        // the combinational jump still follows its rule.
        b32.i_instr = 32'h0800_0100; b32.i_if_valid = 1'b1; b32.i_next_pc = 32'h0040_0004;
        b32.i_wb_we = 1'b1; b32.i_wb_reg = 5'd4; b32.i_wb_data = 32'h1111_1111;
        repeat (2) tick();
        #1;
        check("rst_jump_comb", b32.o_jump, 1'b1);
        check("rst_stall", b32.o_stall, 1'b0);
        check("rst_valid", b32.o_valid, 1'b0);
        check("rst_ctrl", {b32.o_wb_ctrl, b32.o_mem_ctrl, b32.o_ex_ctrl}, 9'b0);
        check("rst_fields", {b32.o_rs, b32.o_rt, b32.o_rd}, 15'b0);
        check("rst_imm", b32.o_imm, 32'h0);
        check("rst_next_pc", b32.o_next_pc, 32'h0);
        check("rst64_valid", b64.o_valid, 1'b0);
        rst = 1'b0;
        idle32();
        tick();

        // ---------------- addi $1,$0,5 ----------------
        issue32(32'h2001_0005);
        tick();
        check("addi_valid", b32.o_valid, 1'b1);
        check("addi_imm", b32.o_imm, 32'd5);
        check("addi_rt", b32.o_rt, 5'd1);
        check("addi_wb", b32.o_wb_ctrl, 2'b01);
        check("addi_ex", b32.o_ex_ctrl, 4'b1000);

        // $4 must still be zero: the reset-time writeback was dropped
        issue32(32'h0080_2820);
        tick();
        check("rst_dominates_wb", b32.o_rs_data, 32'h0);

        // ---------------- decode table ----------------
        vecs[0] = '{32'h00A6_1820, 1'b1, 1'b1, {2'b01, 3'b000, 4'b0101}, 32'h0000_1820, 1'b0, 1'b0};
        vecs[1] = '{32'h8D07_FFFC, 1'b1, 1'b1, {2'b11, 3'b010, 4'b1000}, 32'hFFFF_FFFC, 1'b0, 1'b0};
        vecs[2] = '{32'hAD49_0008, 1'b1, 1'b1, {2'b00, 3'b100, 4'b1000}, 32'h0000_0008, 1'b0, 1'b0};
        vecs[3] = '{32'h1022_FFFF, 1'b1, 1'b1, {2'b00, 3'b001, 4'b0010}, 32'hFFFF_FFFF, 1'b0, 1'b0};
        vecs[4] = '{32'h2001_0005, 1'b1, 1'b1, {2'b01, 3'b000, 4'b1000}, 32'h0000_0005, 1'b0, 1'b0};
        vecs[5] = '{32'h0800_0100, 1'b1, 1'b0, 9'b0,                     32'h0000_0100, 1'b1, 1'b0};
        vecs[6] = '{32'hFC00_0000, 1'b1, 1'b0, 9'b0,                     32'h0000_0000, 1'b0, 1'b1};
        vecs[7] = '{32'h00A6_1820, 1'b0, 1'b0, 9'b0,                     32'h0000_1820, 1'b0, 1'b0};
        for (int i = 0; i < 8; i++) begin
            issue32(vecs[i].instr);
            b32.i_if_valid = vecs[i].if_valid;
            #1;
            check($sformatf("tbl%0d_jump", i), b32.o_jump, vecs[i].exp_jump);
            check($sformatf("tbl%0d_illegal", i), b32.o_illegal, vecs[i].exp_illegal);
            tick();
            check($sformatf("tbl%0d_valid", i), b32.o_valid, vecs[i].exp_valid);
            check($sformatf("tbl%0d_ctrl", i), {b32.o_wb_ctrl, b32.o_mem_ctrl, b32.o_ex_ctrl}, vecs[i].exp_ctrl);
            if (vecs[i].exp_valid)
                check($sformatf("tbl%0d_imm", i), b32.o_imm, vecs[i].exp_imm);
        end

        // ---------------- load-use: lw $2,0($1); add $3,$2,$1 ----------------
        issue32(32'h8C22_0000);
        #1 check("lu_lw_stall", b32.o_stall, 1'b0);
        tick();
        check("lu_lw_mem", b32.o_mem_ctrl, 3'b010);
        issue32(32'h0041_1820);
        #1 check("lu_stall", b32.o_stall, 1'b1);
        tick();
        check("lu_bubble_valid", b32.o_valid, 1'b0);
        check("lu_bubble_ctrl", {b32.o_wb_ctrl, b32.o_mem_ctrl, b32.o_ex_ctrl}, 9'b0);
        #1 check("lu_stall_released", b32.o_stall, 1'b0);
        tick();
        check("lu_add_valid", b32.o_valid, 1'b1);
        check("lu_add_rs", b32.o_rs, 5'd2);
        check("lu_add_rt", b32.o_rt, 5'd1);
        check("lu_add_rd", b32.o_rd, 5'd3);

        // ---------------- write-through bypass and $0 ----------------
        issue32(32'h0080_2820);
        b32.i_wb_we = 1'b1; b32.i_wb_reg = 5'd4; b32.i_wb_data = 32'hDEAD_BEEF;
        tick();
        check("bypass_rs4", b32.o_rs_data, 32'hDEAD_BEEF);
        issue32(32'h0000_2820);
        b32.i_wb_reg = 5'd0; b32.i_wb_data = 32'h0000_1234;
        tick();
        check("bypass_r0_rs", b32.o_rs_data, 32'h0);
        check("bypass_r0_rt", b32.o_rt_data, 32'h0);
        b32.i_wb_we = 1'b0;
        issue32(32'h0080_2820);
        tick();
        check("stored_r4", b32.o_rs_data, 32'hDEAD_BEEF);
        check("stored_r0", b32.o_rt_data, 32'h0);

        // ---------------- flush beats hazard ----------------
        issue32(32'h8C22_0000);
        tick();
        issue32(32'h0041_1820);
        b32.i_flush = 1'b1;
        #1 check("flush_hz_stall", b32.o_stall, 1'b0);
        tick();
        check("flush_bubble", b32.o_valid, 1'b0);
        check("flush_bubble_ctrl", {b32.o_wb_ctrl, b32.o_mem_ctrl, b32.o_ex_ctrl}, 9'b0);
        b32.i_flush = 1'b0;

        // ---------------- hold for 3 cycles ----------------
        issue32(32'h2001_0005);
        tick();
        issue32(32'h0800_0100);
        b32.i_hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check($sformatf("hold%0d_stall", i), b32.o_stall, 1'b1);
            check($sformatf("hold%0d_jump", i), b32.o_jump, 1'b0);
            tick();
            check($sformatf("hold%0d_valid", i), b32.o_valid, 1'b1);
            check($sformatf("hold%0d_imm", i), b32.o_imm, 32'd5);
            check($sformatf("hold%0d_ctrl", i), {b32.o_wb_ctrl, b32.o_mem_ctrl, b32.o_ex_ctrl},
                  {2'b01, 3'b000, 4'b1000});
        end
        b32.i_hold = 1'b0;

        // ---------------- jump and illegal ----------------
        issue32(32'h0800_0100);
        b32.i_next_pc = 32'h0040_0004;
        #1;
        check("j_jump", b32.o_jump, 1'b1);
        check("j_tgt", b32.o_jump_tgt, 32'h0000_0400);
        check("j_illegal", b32.o_illegal, 1'b0);
        tick();
        check("j_bubble", b32.o_valid, 1'b0);
        issue32(32'hFC00_0000);
        #1;
        check("ill_illegal", b32.o_illegal, 1'b1);
        check("ill_jump", b32.o_jump, 1'b0);
        tick();
        check("ill_bubble", b32.o_valid, 1'b0);
        idle32();

        // ---------------- 64-bit configuration ----------------
        b64.i_instr = 32'h2001_8000; b64.i_if_valid = 1'b1; b64.i_next_pc = 64'h10;
        tick();
        check("w64_imm", b64.o_imm, 64'hFFFF_FFFF_FFFF_8000);
        idle64();
        b64.i_wb_we = 1'b1; b64.i_wb_reg = 6'd33; b64.i_wb_data = 64'hAAAA_AAAA_AAAA_AAAA;
        tick();
        b64.i_wb_reg = 6'd31; b64.i_wb_data = 64'h0123_4567_89AB_CDEF;
        tick();
        idle64();
        b64.i_instr = 32'h03E1_2820; b64.i_if_valid = 1'b1;
        tick();
        check("w64_r31", b64.o_rs_data, 64'h0123_4567_89AB_CDEF);
        check("w64_r1_not_33", b64.o_rt_data, 64'h0);
        check("w64_rs", b64.o_rs, 6'd31);
        b64.i_instr = 32'h0800_0100; b64.i_next_pc = 64'hFFFF_0000_1000_0004;
        #1;
        check("w64_jump", b64.o_jump, 1'b1);
        check("w64_tgt", b64.o_jump_tgt, 64'hFFFF_0000_1000_0400);
        idle64();

        // ---------------- randomized run against the model ----------------
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int r = 0; r < 32; r++) m_regs[r] = 32'h0;
        m_valid = 1'b0; m_ctrl = 9'b0;
        m_next_pc = '0; m_rs_data = '0; m_rt_data = '0; m_imm = '0;
        m_rs = '0; m_rt = '0; m_rd = '0;

        for (int c = 0; c < 400; c++) begin
            logic [5:0]  op;
            logic [4:0]  f_rs, f_rt;
            logic [31:0] ins, npc, wdata;
            logic        ifv, fl, hd, we, legal, is_j, e_haz, e_stall, e_fire, n_valid;
            logic [4:0]  wreg;
            logic [8:0]  ctrl;
            case ($urandom_range(0, 7))
                0: op = 6'h00;  1: op = 6'h23;  2: op = 6'h2B;  3: op = 6'h04;
                4: op = 6'h08;  5: op = 6'h02;  6: op = 6'($urandom); default: op = 6'h23;
            endcase
            f_rs  = 5'($urandom_range(0, 3));
            f_rt  = 5'($urandom_range(0, 3));
            ins   = {op, f_rs, f_rt, 16'($urandom)};
            npc   = $urandom;
            ifv   = ($urandom_range(0, 7) != 0);
            fl    = ($urandom_range(0, 7) == 0);
            hd    = ($urandom_range(0, 7) == 0);
            we    = $urandom_range(0, 1) == 1;
            wreg  = 5'($urandom_range(0, 3));
            wdata = $urandom;
            b32.i_instr = ins; b32.i_next_pc = npc; b32.i_if_valid = ifv;
            b32.i_flush = fl; b32.i_hold = hd;
            b32.i_wb_we = we; b32.i_wb_reg = wreg; b32.i_wb_data = wdata;

            spec_ctrl(op, legal, is_j, ctrl);
            e_haz   = ifv && m_valid && m_ctrl[5] && (m_rt != 0) &&
                      ((m_rt == f_rs) || ((m_rt == f_rt) && (op == 6'h00 || op == 6'h2B || op == 6'h04)));
            e_stall = hd || (e_haz && !fl);
            e_fire  = ifv && !e_stall && !fl;
            #1;
            check($sformatf("rnd%0d_stall", c), b32.o_stall, e_stall);
            check($sformatf("rnd%0d_jump", c), b32.o_jump, e_fire && is_j);
            check($sformatf("rnd%0d_illegal", c), b32.o_illegal, e_fire && !legal);
            if (e_fire && is_j)
                check($sformatf("rnd%0d_tgt", c), b32.o_jump_tgt, {npc[31:28], ins[25:0], 2'b00});

            if (fl || (!hd && e_haz)) begin
                m_valid = 1'b0; m_ctrl = 9'b0;
            end else if (!hd) begin
                n_valid   = ifv && legal && !is_j;
                m_valid   = n_valid;
                m_ctrl    = n_valid ? ctrl : 9'b0;
                m_next_pc = npc;
                m_rs_data = model_read(f_rs, we, wreg, wdata);
                m_rt_data = model_read(f_rt, we, wreg, wdata);
                m_imm     = 32'(signed'(ins[15:0]));
                m_rs = f_rs; m_rt = f_rt; m_rd = ins[15:11];
            end
            if (we && wreg != 0) m_regs[wreg] = wdata;

            tick();
            check($sformatf("rnd%0d_valid", c), b32.o_valid, m_valid);
            check($sformatf("rnd%0d_ctrl", c), {b32.o_wb_ctrl, b32.o_mem_ctrl, b32.o_ex_ctrl}, m_ctrl);
            if (m_valid) begin
                check($sformatf("rnd%0d_rs_data", c), b32.o_rs_data, m_rs_data);
                check($sformatf("rnd%0d_rt_data", c), b32.o_rt_data, m_rt_data);
                check($sformatf("rnd%0d_imm", c), b32.o_imm, m_imm);
                check($sformatf("rnd%0d_regs", c), {b32.o_rs, b32.o_rt, b32.o_rd}, {m_rs, m_rt, m_rd});
                check($sformatf("rnd%0d_next_pc", c), b32.o_next_pc, m_next_pc);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
